// File: rtl/mcy_enc_pkg.sv
// Shared opcodes, class/state enums, LFSR mask and the combinational
// LFSR-to-instruction encoder used by the MCY decoder stimulus block.
package mcy_enc_pkg;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [3:0] {
    CLS_LUI    = 4'd0,
    CLS_AUIPC  = 4'd1,
    CLS_JAL    = 4'd2,
    CLS_JALR   = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_LOAD   = 4'd5,
    CLS_STORE  = 4'd6,
    CLS_OP_IMM = 4'd7,
    CLS_OP     = 4'd8,
    CLS_MULDIV = 4'd9,
    CLS_FENCE  = 4'd10,
    CLS_SYSTEM = 4'd11
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0]  word;
    instr_class_e cls;
  } enc_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? LFSR_MASK : 32'h0);
  endfunction

  function automatic enc_t encode(input logic [31:0] l, input logic en_rvm);
    enc_t        e;
    logic [2:0]  f3;
    logic [2:0]  f3_ld;
    logic [2:0]  f3_st;
    logic [6:0]  f7_imm;
    logic [6:0]  f7_op;
    logic [31:0] op_word;
    f3      = l[14:12];
    f3_ld   = f3[2] ? {2'b10, f3[0]} : ((f3 == 3'd3) ? 3'd2 : f3);
    f3_st   = (f3[1:0] == 2'd3) ? 3'd2 : {1'b0, f3[1:0]};
    f7_imm  = (f3 == 3'd1) ? 7'h00 :
              (f3 == 3'd5) ? {1'b0, l[30], 5'b0} : l[31:25];
    f7_op   = ((f3 == 3'd0) || (f3 == 3'd5)) ? {1'b0, l[30], 5'b0} : 7'h00;
    op_word = {f7_op, l[24:15], f3, l[11:7], OPC_OP};
    e.word  = {l[31:7], OPC_LUI};
    e.cls   = CLS_LUI;
    case (l[3:0])
      4'd0: begin e.word = {l[31:7], OPC_LUI};   e.cls = CLS_LUI;   end
      4'd1: begin e.word = {l[31:7], OPC_AUIPC}; e.cls = CLS_AUIPC; end
      4'd2: begin e.word = {l[31:7], OPC_JAL};   e.cls = CLS_JAL;   end
      4'd3: begin e.word = {l[31:15], 3'b000, l[11:7], OPC_JALR}; e.cls = CLS_JALR; end
      // f3 2/3 are reserved branch encodings; setting bit 14 turns them into BLTU/BGEU.
      4'd4: begin
        e.word = {l[31:15], f3[2] | f3[1], f3[1:0], l[11:7], OPC_BRANCH};
        e.cls  = CLS_BRANCH;
      end
      4'd5: begin e.word = {l[31:15], f3_ld, l[11:7], OPC_LOAD};  e.cls = CLS_LOAD;  end
      4'd6: begin e.word = {l[31:15], f3_st, l[11:7], OPC_STORE}; e.cls = CLS_STORE; end
      4'd8: begin e.word = op_word; e.cls = CLS_OP; end
      4'd9: begin
        e.word = en_rvm ? {7'h01, l[24:15], f3, l[11:7], OPC_OP} : op_word;
        e.cls  = CLS_MULDIV;
      end
      4'd10: begin e.word = 32'h0FF0_000F; e.cls = CLS_FENCE; end
      4'd11: begin
        e.cls = CLS_SYSTEM;
        case (l[5:4])
          2'd0:    e.word = 32'h0000_0073;
          2'd1:    e.word = 32'h0010_0073;
          2'd2:    e.word = {12'h340, l[19:15], 3'b001, l[11:7], OPC_SYSTEM};
          default: e.word = {12'h340, l[19:15], 3'b010, l[11:7], OPC_SYSTEM};
        endcase
      end
      // Class 7 and the otherwise unused codes 12-15 all fold into OP-IMM.
      default: begin
        e.word = {f7_imm, l[24:15], f3, l[11:7], OPC_OP_IMM};
        e.cls  = CLS_OP_IMM;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mcy_lfsr32.sv
// 32-bit right-shift Galois LFSR with synchronous load and single-step advance.
module mcy_lfsr32
  import mcy_enc_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1D87_2B41
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        step_i,
  output logic [31:0] state_o
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = seed_i;
    end else if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/mcy_decoder_stim_encoder.sv
// LFSR-driven RV32I/M instruction producer with a registered valid/ready output
// stage; emits NUM_INSTR legal encodings per run and then reports done.
module mcy_decoder_stim_encoder
  import mcy_enc_pkg::*;
#(
  parameter int unsigned NUM_INSTR = 256,
  parameter logic [31:0] LFSR_SEED = 32'h1D87_2B41,
  parameter bit          EN_RVM    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] seed_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [3:0]  instr_class_o,
  output logic [15:0] count_o,
  output logic        done_o
);

  // Handshake: a word transfers on a rising edge where instr_valid_o and
  // instr_ready_i are both high; while valid is high and ready is low the
  // word, class and count are held unchanged.

  localparam logic [15:0] LAST_COUNT = 16'(NUM_INSTR - 1);

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  class_q, class_d;
  logic [15:0] count_q, count_d;

  logic        lfsr_load;
  logic        lfsr_step;
  logic [31:0] lfsr_state;
  logic [31:0] seed_eff;
  logic [31:0] lfsr_upcoming;
  enc_t        enc;

  assign seed_eff = (seed_i == 32'h0) ? LFSR_SEED : seed_i;

  mcy_lfsr32 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (lfsr_load),
    .seed_i  (seed_eff),
    .step_i  (lfsr_step),
    .state_o (lfsr_state)
  );

  // Output registers capture the encoding of the value the LFSR is about to hold.
  assign lfsr_upcoming = lfsr_load ? seed_eff : lfsr_next(lfsr_state);
  assign enc           = encode(lfsr_upcoming, EN_RVM);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    done_d    = done_q;
    rdata_d   = rdata_q;
    class_d   = class_q;
    count_d   = count_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      ST_EMIT: begin
        if (instr_ready_i) begin
          lfsr_step = 1'b1;
          count_d   = count_q + 16'd1;
          rdata_d   = enc.word;
          class_d   = enc.cls;
          if (count_q == LAST_COUNT) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        if (start_i) begin
          lfsr_load = 1'b1;
          state_d   = ST_EMIT;
          valid_d   = 1'b1;
          done_d    = 1'b0;
          count_d   = 16'd0;
          rdata_d   = enc.word;
          class_d   = enc.cls;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 32'h0;
      class_q <= 4'h0;
      count_q <= 16'h0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      class_q <= class_d;
      count_q <= count_d;
    end
  end

  assign instr_valid_o = valid_q;
  assign instr_rdata_o = rdata_q;
  assign instr_class_o = class_q;
  assign count_o       = count_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_mcy_decoder_stim_encoder.sv
// Scoreboard bench for mcy_decoder_stim_encoder: a reference LFSR/encoder model
// fills the expected queue on each start and every handshake pops one entry.
module tb_mcy_decoder_stim_encoder;

  localparam int          N_INSTR = 4;
  localparam logic [31:0] SEED    = 32'h1D87_2B41;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [31:0] seed_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_rdata_o;
  logic [3:0]  instr_class_o;
  logic [15:0] count_o;
  logic        done_o;

  int          checks;
  int          errors;
  int          hs_count;
  logic [15:0] cover_hit;
  logic [35:0] exp_q[$];

  mcy_decoder_stim_encoder #(
    .NUM_INSTR (N_INSTR),
    .LFSR_SEED (SEED),
    .EN_RVM    (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .seed_i        (seed_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_rdata_o (instr_rdata_o),
    .instr_class_o (instr_class_o),
    .count_o       (count_o),
    .done_o        (done_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_step(input logic [31:0] l);
    logic [31:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  // Reference encoding: {class[3:0], word[31:0]}
  function automatic logic [35:0] model_enc(input logic [31:0] l);
    logic [3:0]  c;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] w;
    c   = l[3:0];
    f3  = l[14:12];
    f7  = l[31:25];
    opc = 7'h00;
    if (c >= 4'd12) c = 4'd7;
    case (c)
      4'd0: opc = 7'h37;
      4'd1: opc = 7'h17;
      4'd2: opc = 7'h6F;
      4'd3: begin opc = 7'h67; f3 = 3'd0; end
      4'd4: begin opc = 7'h63; if (f3 == 3'd2 || f3 == 3'd3) f3[2] = 1'b1; end
      4'd5: begin
        opc = 7'h03;
        if (f3[2]) f3 = {2'b10, f3[0]};
        else if (f3 == 3'd3) f3 = 3'd2;
      end
      4'd6: begin
        opc = 7'h23;
        f3  = {1'b0, f3[1:0]};
        if (f3 == 3'd3) f3 = 3'd2;
      end
      4'd7: begin
        opc = 7'h13;
        if (f3 == 3'd1) f7 = 7'h00;
        else if (f3 == 3'd5) f7 = {1'b0, l[30], 5'b0};
      end
      4'd8: begin
        opc = 7'h33;
        f7  = (f3 == 3'd0 || f3 == 3'd5) ? {1'b0, l[30], 5'b0} : 7'h00;
      end
      4'd9: begin opc = 7'h33; f7 = 7'h01; end
      default: opc = 7'h73;
    endcase
    w = {f7, l[24:20], l[19:15], f3, l[11:7], opc};
    if (c == 4'd10) w = 32'h0FF0_000F;
    if (c == 4'd11) begin
      case (l[5:4])
        2'd0:    w = 32'h0000_0073;
        2'd1:    w = 32'h0010_0073;
        2'd2:    w = {12'h340, l[19:15], 3'b001, l[11:7], 7'h73};
        default: w = {12'h340, l[19:15], 3'b010, l[11:7], 7'h73};
      endcase
    end
    return {c, w};
  endfunction

  // Independent RV32IM legality rules, the way a decoder would judge the word.
  function automatic bit is_legal(input logic [31:0] w);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    case (opc)
      7'h37, 7'h17, 7'h6F: return 1'b1;
      7'h67: return f3 == 3'd0;
      7'h63: return f3 != 3'd2 && f3 != 3'd3;
      7'h03: return f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7;
      7'h23: return f3 <= 3'd2;
      7'h13: begin
        if (f3 == 3'd1) return f7 == 7'h00;
        if (f3 == 3'd5) return f7 == 7'h00 || f7 == 7'h20;
        return 1'b1;
      end
      7'h33: begin
        if (f7 == 7'h00 || f7 == 7'h01) return 1'b1;
        if (f7 == 7'h20) return f3 == 3'd0 || f3 == 3'd5;
        return 1'b0;
      end
      7'h0F: return f3 == 3'd0;
      7'h73: begin
        if (w == 32'h0000_0073 || w == 32'h0010_0073) return 1'b1;
        return f3 != 3'd0 && f3 != 3'd4;
      end
      default: return 1'b0;
    endcase
  endfunction

  // Scoreboard: sampled 1 time unit after the falling edge, so it sees the
  // ready value that the next rising edge will use.
  always @(negedge clk) begin
    logic [35:0] exp_v;
    #1;
    if (!rst && instr_valid_o && instr_ready_i) begin
      hs_count = hs_count + 1;
      checks   = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb_unexpected got word %h class %0d, expected queue empty",
                 instr_rdata_o, instr_class_o);
      end else begin
        exp_v = exp_q.pop_front();
        if ({instr_class_o, instr_rdata_o} !== exp_v) begin
          errors = errors + 1;
          $display("FAIL sb_word got %h class %0d, expected %h class %0d",
                   instr_rdata_o, instr_class_o, exp_v[31:0], exp_v[35:32]);
        end
      end
      checks = checks + 1;
      if (!is_legal(instr_rdata_o)) begin
        errors = errors + 1;
        $display("FAIL legal got illegal word %h, expected a legal RV32IM word", instr_rdata_o);
      end
      cover_hit[instr_class_o] = 1'b1;
    end
  end

  // driver tasks
  task automatic start_run(input logic [31:0] s);
    logic [31:0] l;
    @(negedge clk);
    start_i       = 1'b1;
    seed_i        = s;
    instr_ready_i = 1'b0;
    l = (s == 32'h0) ? SEED : s;
    for (int i = 0; i < N_INSTR; i++) begin
      exp_q.push_back(model_enc(l));
      l = model_step(l);
    end
    @(negedge clk);
    start_i = 1'b0;
    #1;
    checks = checks + 1;
    if (instr_valid_o !== 1'b1 || done_o !== 1'b0 || count_o !== 16'd0) begin
      errors = errors + 1;
      $display("FAIL start got valid %b done %b count %0d, expected valid 1 done 0 count 0",
               instr_valid_o, done_o, count_o);
    end
  endtask

  task automatic wait_done(input bit random_ready);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      instr_ready_i = random_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (done_o === 1'b1) seen = 1'b1;
    end
    checks = checks + 1;
    if (!seen) begin
      errors = errors + 1;
      $display("FAIL done_timeout got done 0 after 200 cycles, expected done 1");
    end
    checks = checks + 1;
    if (exp_q.size() != 0 || count_o !== 16'(N_INSTR) || instr_valid_o !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL done_state got queue %0d count %0d valid %b, expected queue 0 count %0d valid 0",
               exp_q.size(), count_o, instr_valid_o, N_INSTR);
    end
    @(negedge clk);
    instr_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks = checks + 1;
    if (instr_valid_o !== 1'b0 || instr_rdata_o !== 32'h0 || instr_class_o !== 4'h0 ||
        count_o !== 16'h0 || done_o !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset got valid %b word %h class %0d count %0d done %b, expected all zero",
               instr_valid_o, instr_rdata_o, instr_class_o, count_o, done_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed_words();
    start_run(32'h1234_5670);
    checks = checks + 1;
    if (instr_rdata_o !== 32'h1234_5637 || instr_class_o !== 4'd0) begin
      errors = errors + 1;
      $display("FAIL lui_word got %h class %0d, expected 12345637 class 0",
               instr_rdata_o, instr_class_o);
    end
    wait_done(1'b0);
    start_run(32'h0000_000B);
    checks = checks + 1;
    if (instr_rdata_o !== 32'h0000_0073 || instr_class_o !== 4'd11) begin
      errors = errors + 1;
      $display("FAIL ecall_word got %h class %0d, expected 00000073 class 11",
               instr_rdata_o, instr_class_o);
    end
    wait_done(1'b0);
    start_run(32'h0000_001B);
    checks = checks + 1;
    if (instr_rdata_o !== 32'h0010_0073 || instr_class_o !== 4'd11) begin
      errors = errors + 1;
      $display("FAIL ebreak_word got %h class %0d, expected 00100073 class 11",
               instr_rdata_o, instr_class_o);
    end
    wait_done(1'b0);
  endtask

  task automatic test_seed_zero();
    start_run(32'h0);
    checks = checks + 1;
    if (instr_rdata_o !== 32'h1D87_2B17 || instr_class_o !== 4'd1) begin
      errors = errors + 1;
      $display("FAIL seed_zero got %h class %0d, expected 1d872b17 class 1",
               instr_rdata_o, instr_class_o);
    end
    wait_done(1'b0);
  endtask

  task automatic test_completion();
    int hs_start;
    hs_start = hs_count;
    start_run($urandom());
    wait_done(1'b0);
    checks = checks + 1;
    if (hs_count - hs_start != N_INSTR) begin
      errors = errors + 1;
      $display("FAIL hs_count got %0d handshakes, expected %0d", hs_count - hs_start, N_INSTR);
    end
    repeat (3) begin
      @(negedge clk);
      instr_ready_i = 1'b1;
      #1;
      checks = checks + 1;
      if (instr_valid_o !== 1'b0 || done_o !== 1'b1) begin
        errors = errors + 1;
        $display("FAIL after_done got valid %b done %b, expected valid 0 done 1",
                 instr_valid_o, done_o);
      end
    end
    @(negedge clk);
    instr_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    start_run(32'hCAFE_0009);
    for (int i = 0; i < N_INSTR; i++) begin
      @(negedge clk);
      instr_ready_i = 1'b1;
      #1;
      checks = checks + 1;
      if (count_o !== 16'(i) || instr_valid_o !== 1'b1) begin
        errors = errors + 1;
        $display("FAIL b2b_count got count %0d valid %b, expected count %0d valid 1",
                 count_o, instr_valid_o, i);
      end
    end
    @(negedge clk);
    instr_ready_i = 1'b0;
    #1;
    checks = checks + 1;
    if (done_o !== 1'b1 || count_o !== 16'(N_INSTR) || instr_valid_o !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL b2b_done got done %b count %0d valid %b, expected done 1 count %0d valid 0",
               done_o, count_o, instr_valid_o, N_INSTR);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] snap_word;
    start_run(32'h5A5A_3C3C);
    @(negedge clk);
    instr_ready_i = 1'b1;
    @(negedge clk);
    instr_ready_i = 1'b0;
    #1;
    snap_word = instr_rdata_o;
    checks = checks + 1;
    if (count_o !== 16'd1) begin
      errors = errors + 1;
      $display("FAIL bp_count got %0d, expected 1", count_o);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      // start_i while emitting must be ignored
      start_i = (i == 2);
      seed_i  = 32'h0000_000B;
      #1;
      checks = checks + 1;
      if (instr_rdata_o !== snap_word || count_o !== 16'd1 || instr_valid_o !== 1'b1) begin
        errors = errors + 1;
        $display("FAIL bp_hold got word %h count %0d valid %b, expected word %h count 1 valid 1",
                 instr_rdata_o, count_o, instr_valid_o, snap_word);
      end
    end
    @(negedge clk);
    start_i = 1'b0;
    wait_done(1'b0);
  endtask

  task automatic test_random();
    cover_hit = '0;
    for (int r = 0; r < 400; r++) begin
      start_run($urandom());
      wait_done(1'b1);
    end
    for (int c = 0; c < 12; c++) begin
      checks = checks + 1;
      if (cover_hit[c] !== 1'b1) begin
        errors = errors + 1;
        $display("FAIL class_cover got class %0d unhit, expected hit", c);
      end
    end
    checks = checks + 1;
    if (cover_hit[15:12] !== 4'h0) begin
      errors = errors + 1;
      $display("FAIL class_range got classes 12-15 mask %b, expected 0000", cover_hit[15:12]);
    end
  endtask

  task automatic test_rst_mid_run();
    start_run(32'h7777_1235);
    @(negedge clk);
    instr_ready_i = 1'b1;
    @(negedge clk);
    instr_ready_i = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    #1;
    checks = checks + 1;
    if (instr_valid_o !== 1'b0 || instr_rdata_o !== 32'h0 || instr_class_o !== 4'h0 ||
        count_o !== 16'h0 || done_o !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL rst_mid got valid %b word %h class %0d count %0d done %b, expected all zero",
               instr_valid_o, instr_rdata_o, instr_class_o, count_o, done_o);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    // after reset the LFSR is back at its seed; a start with seed 0 proves it restarts cleanly
    test_seed_zero();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    hs_count      = 0;
    cover_hit     = '0;
    rst           = 1'b1;
    start_i       = 1'b0;
    seed_i        = 32'h0;
    instr_ready_i = 1'b0;
    test_reset();
    test_directed_words();
    test_seed_zero();
    test_completion();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_rst_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcy_decoder_stim_encoder.md
# mcy_decoder_stim_encoder

Instruction encoder feeding the mutated `cv32e40p_decoder` in the MCY decoder bench: it plays the producer role for the decoder's `instr_rdata_i`. A 32-bit LFSR drives it, and it emits only legal RV32I/RV32M encodings across all major opcode classes over a valid/ready handshake. It stops after a programmed number of instructions, so the reference and mutated decoders see an identical, reproducible instruction stream for each seed.

## Interface
Parameters:
- `NUM_INSTR`, 256: instructions emitted per run, range 1..65535.
- `LFSR_SEED`, 32'h1D87_2B41: reset value of the LFSR, and the substitute used whenever `seed_i` is zero.
- `EN_RVM`, 1: when 1, class 9 encodes MUL/DIV; when 0, class 9 encodes OP.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state on the rising edge.
- `rst` in 1: synchronous active-high reset.
- `start_i` in 1: starts a run; honoured only in IDLE or DONE.
- `seed_i` in 32: LFSR seed, sampled on an accepted `start_i`.
- `instr_valid_o` out 1: `instr_rdata_o` holds a valid instruction.
- `instr_ready_i` in 1: consumer accepts the instruction.
- `instr_rdata_o` out 32: encoded instruction.
- `instr_class_o` out 4: class of the instruction currently presented.
- `count_o` out 16: number of instructions accepted in this run.
- `done_o` out 1: run complete.

## Operation
- **FSM states:** IDLE, EMIT, DONE.
- **IDLE, `start_i`=1:** LFSR loads `seed_i`, or `LFSR_SEED` if `seed_i`==0. `count_o` clears to 0. The FSM moves to EMIT.
- **EMIT:** `instr_valid_o`=1 and the outputs present the encoding of the current LFSR state.
- **Handshake in EMIT (`instr_valid_o` & `instr_ready_i`):**
  - the LFSR advances one step and `count_o` increments;
  - if the pre-increment count equals `NUM_INSTR`-1, the FSM moves to DONE.
- **DONE:** `done_o`=1 and `instr_valid_o`=0. `start_i` here behaves as it does in IDLE.
- **`start_i` during EMIT:** ignored.
- **LFSR:** right-shift Galois. next = {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 0).
- **Base word:** {l[31:7], opc}, so rd=l[11:7], f3=l[14:12], rs1=l[19:15], rs2=l[24:20]. The class is l[3:0], and bits 6:0 are always overwritten by `opc`.
- **Class encodings:**
  - 0 LUI.
  - 1 AUIPC.
  - 2 JAL.
  - 3 JALR, with f3 forced to 0.
  - 4 BRANCH; if f3 is 2 or 3, bit 14 is forced to 1.
  - 5 LOAD; f3[2]=1 gives {1,0,f3[0]}, f3=3 gives 2.
  - 6 STORE; f3 becomes {0, f3[1:0]}, and 3 maps to 2.
  - 7 and 12–15 OP-IMM:
    - f3=1 forces funct7=0;
    - f3=5 gives funct7 = {1'b0, l[30], 5'b0};
    - other f3 values keep the immediate.
  - 8 OP; funct7 = l[30]<<5 when f3 is 0 or 5, otherwise 0.
  - 9 MUL/DIV, funct7=7'h01 (or OP when `EN_RVM`=0).
  - 10 FENCE, fixed word 32'h0FF0_000F.
  - 11 SYSTEM, selected by l[5:4]:
    - 0: ECALL, 32'h0000_0073;
    - 1: EBREAK, 32'h0010_0073;
    - 2: CSRRW, csr 12'h340;
    - 3: CSRRS, csr 12'h340.
- **`instr_class_o`:** the class after remapping, so classes 12–15 report 7.

## Timing
- **Reset values:** state IDLE, LFSR=`LFSR_SEED`, `instr_valid_o`=0, `instr_rdata_o`=0, `instr_class_o`=0, `count_o`=0, `done_o`=0.
- **Start latency:** `start_i` sampled at edge N gives `instr_valid_o`=1 with the first word after edge N.
- **Outputs are registered.** The next word appears one cycle after each handshake. With `instr_ready_i` held high, throughput is one instruction per cycle.
- **Backpressure:** with `instr_valid_o`=1 and `instr_ready_i`=0, `instr_rdata_o`, `instr_class_o` and `count_o` hold stable.
- **Completion:** `done_o` rises in the cycle after the final handshake, with `count_o`=`NUM_INSTR`.
- **`rst` mid-run:** all outputs take their reset values on the next edge. No partial word is retained.
- **`NUM_INSTR`=1:** DONE follows the first handshake.

## Structure
- **Package `mcy_enc_pkg`:**
  - opcode localparams (LUI 7'h37, AUIPC 7'h17, JAL 7'h6F, JALR 7'h67, BRANCH 7'h63, LOAD 7'h03, STORE 7'h23, OP-IMM 7'h13, OP 7'h33, FENCE 7'h0F, SYSTEM 7'h73);
  - the `instr_class_e` enum;
  - the LFSR mask 32'h8020_0003;
  - the `state_e` enum.
- **Sub-module `mcy_lfsr32`:** holds the register, the `load`/`seed`/`step` inputs and the state output.
- The encoder is a combinational function of the LFSR state, registered at the top level.

## Test plan
- `seed_i`=32'h1234_5670, ready=1 → first word 32'h1234_5637, class 0.
- `seed_i`=32'h0000_000B → 32'h0000_0073, class 11; `seed_i`=32'h0000_001B → 32'h0010_0073.
- `seed_i`=0 → first word equals the encoding of `LFSR_SEED`.
- `NUM_INSTR`=4, ready=1 → exactly 4 handshakes; `done_o`=1 and `count_o`=4 the next cycle; valid=0 afterwards.
- Ready low for 5 cycles mid-run → `instr_rdata_o` and `count_o` are unchanged across those cycles; the stream continues identically afterwards.
- 65535 random instructions → every word decodes with `illegal_insn_o`=0 on the unmutated decoder, and every class 0–11 is hit; `rst` pulsed mid-run returns to IDLE with valid=0.
